// File: rtl/sram_fifo_ctrl.sv
// Circular FIFO controller that stores 128-bit entries in an external
// single-port SRAM, one SRAM operation at a time, with a one-entry output register.
module sram_fifo_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int unsigned DEPTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [127:0]             in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [127:0]             out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sram_read,
    output logic                     sram_write,
    output logic [15:0]              sram_addr,
    output logic [127:0]             sram_wdata,
    input  logic [127:0]             sram_rdata
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ,
        READ_CAP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               rst_q;
    logic               pop_ok;
    logic               read_go;
    logic               not_full;
    logic               push;
    logic               pop;
    logic [15:0]        wr_addr;
    logic [15:0]        rd_addr;

    assign pop_ok   = !out_valid || out_ready;
    assign not_full = count < CNT_W'(DEPTH);
    assign read_go  = pop_ok && (count != '0);
    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign wr_addr  = BASE_ADDR + (16'(wr_ptr) << 4);
    assign rd_addr  = BASE_ADDR + (16'(rd_ptr) << 4);

    // Next state and SRAM strobes; strobes are forced idle while rst is high.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        sram_read  = 1'b0;
        sram_write = 1'b0;
        sram_addr  = BASE_ADDR;
        case (state_q)
            IDLE: begin
                // Reads win over writes; acceptance is also held off the cycle after reset.
                in_ready = !rst && !rst_q && !read_go && not_full;
                if (read_go) begin
                    state_d = READ;
                end else if (in_valid && in_ready) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                sram_write = !rst;
                sram_addr  = rst ? BASE_ADDR : wr_addr;
                state_d    = IDLE;
            end
            READ: begin
                sram_read = !rst;
                sram_addr = rst ? BASE_ADDR : rd_addr;
                state_d   = READ_CAP;
            end
            READ_CAP: begin
                sram_read = !rst;
                sram_addr = rst ? BASE_ADDR : rd_addr;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // State, pointers, occupancy, write holding register and output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            sram_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                sram_wdata <= in_data;
            end
            if (state_q == WRITE) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                count  <= count + CNT_W'(1);
            end
            // A capture landing on the same edge as a pop keeps out_valid set.
            if (state_q == READ_CAP) begin
                out_data  <= sram_rdata;
                out_valid <= 1'b1;
                rd_ptr    <= rd_ptr + PTR_W'(1);
                count     <= count - CNT_W'(1);
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural synchronous SRAM and
// monitors that log SRAM accesses and popped entries.
module tb_sram_fifo_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] BASE  = 16'h1000;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [2:0]   count;
    logic         sram_read;
    logic         sram_write;
    logic [15:0]  sram_addr;
    logic [127:0] sram_wdata;
    logic [127:0] sram_rdata;

    sram_fifo_ctrl #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .sram_read  (sram_read),
        .sram_write (sram_write),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM: one cycle read latency, indexed by 16-byte word.
    logic [127:0] mem [0:4095];
    always @(posedge clk) begin
        if (sram_write) mem[sram_addr[15:4]] <= sram_wdata;
        if (sram_read)  sram_rdata <= mem[sram_addr[15:4]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic         mon_en = 1'b0;
    logic         prev_read = 1'b0;
    logic [15:0]  wq[$];
    logic [15:0]  rq[$];
    logic [127:0] popq[$];

    always @(negedge clk) begin
        if (mon_en) begin
            check("rw_exclusive", 128'(sram_read && sram_write), 128'(0));
            check("count_max", 128'(count <= 3'(DEPTH)), 128'(1));
            if (sram_write) wq.push_back(sram_addr);
            if (sram_read && !prev_read) rq.push_back(sram_addr);
            if (out_valid && out_ready) popq.push_back(out_data);
            prev_read = sram_read;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step;
        step;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_sram_read", 128'(sram_read), 128'(0));
        check("rst_sram_write", 128'(sram_write), 128'(0));
        check("rst_addr", 128'(sram_addr), 128'(BASE));
        check("rst_count", 128'(count), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_wdata", sram_wdata, 128'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 128'(in_ready), 128'(0));
        step;
        wq.delete();
        rq.delete();
        popq.delete();
        mon_en = 1'b1;
    endtask

    task automatic push(input logic [127:0] d);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data = d;
        #1;
        while (!in_ready && k < 60) begin
            step;
            k++;
        end
        check("push_wait", 128'(k < 60), 128'(1));
        step;
        in_valid = 1'b0;
    endtask

    task automatic wait_pops(input int n);
        int k;
        k = 0;
        while (popq.size() < n && k < 200) begin
            step;
            k++;
        end
        check("drain_wait", 128'(popq.size()), 128'(n));
    endtask

    logic [127:0] e [0:9];
    logic [127:0] a5;
    logic [127:0] b6;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        a5 = {16{8'hA5}};
        b6 = {16{8'hB6}};

        // Single push latency, read priority over continuous write requests.
        reset_dut;
        in_valid = 1'b1;
        in_data = a5;
        #1;
        check("t1_in_ready_idle", 128'(in_ready), 128'(1));
        step;                                   // E0: accepted
        check("t1_write", 128'(sram_write), 128'(1));
        check("t1_write_addr", 128'(sram_addr), 128'(BASE));
        check("t1_wdata", sram_wdata, a5);
        check("t1_in_ready_write", 128'(in_ready), 128'(0));
        in_data = b6;
        step;                                   // E1: idle, count 1
        check("t1_count1", 128'(count), 128'(1));
        check("t1_read_priority", 128'(in_ready), 128'(0));
        check("t1_idle_strobes", 128'({sram_read, sram_write}), 128'(0));
        check("t1_idle_addr", 128'(sram_addr), 128'(BASE));
        step;                                   // E2: READ
        check("t1_read", 128'(sram_read), 128'(1));
        check("t1_read_addr", 128'(sram_addr), 128'(BASE));
        step;                                   // E3: READ_CAP
        check("t1_cap_read", 128'(sram_read), 128'(1));
        check("t1_cap_addr", 128'(sram_addr), 128'(BASE));
        check("t1_cap_out_valid", 128'(out_valid), 128'(0));
        step;                                   // E4: output valid
        check("t1_out_valid", 128'(out_valid), 128'(1));
        check("t1_out_data", out_data, a5);
        check("t1_count0", 128'(count), 128'(0));
        check("t1_in_ready_again", 128'(in_ready), 128'(1));
        step;                                   // E5: second entry accepted
        in_valid = 1'b0;
        check("t1_write2_addr", 128'(sram_addr), 128'(BASE + 16'd16));
        check("t1_wdata2", sram_wdata, b6);
        step;
        check("t1_count_hold", 128'(count), 128'(1));
        check("t1_out_hold", out_data, a5);
        out_ready = 1'b1;
        step;                                   // pop and start READ together
        out_ready = 1'b0;
        check("t1_pop_clears", 128'(out_valid), 128'(0));
        check("t1_read2", 128'(sram_read), 128'(1));
        check("t1_read2_addr", 128'(sram_addr), 128'(BASE + 16'd16));
        step;
        step;
        check("t1_out_data2", out_data, b6);
        check("t1_out_valid2", 128'(out_valid), 128'(1));
        check("t1_count_end", 128'(count), 128'(0));

        // Fill to full with the output stalled.
        reset_dut;
        for (int i = 0; i < 6; i++) e[i] = {4{32'hC0DE_0000 + 32'(i)}};
        for (int i = 0; i < 4; i++) push(e[i]);
        step;
        check("t2_count3", 128'(count), 128'(3));
        check("t2_out_data", out_data, e[0]);
        check("t2_out_valid", 128'(out_valid), 128'(1));
        push(e[4]);
        step;
        check("t2_count4", 128'(count), 128'(4));
        in_valid = 1'b1;
        in_data = e[5];
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_full_in_ready", 128'(in_ready), 128'(0));
            step;
        end
        in_valid = 1'b0;
        check("t2_write_count", 128'(wq.size()), 128'(5));
        for (int i = 0; i < 5; i++)
            check("t2_write_addr", 128'((i < wq.size()) ? wq[i] : 16'hFFFF),
                  128'(BASE + 16'(16 * (i % 4))));
        check("t2_read_count", 128'(rq.size()), 128'(1));
        out_ready = 1'b1;
        wait_pops(5);
        for (int i = 0; i < 5; i++)
            check("t2_pop_order", (i < popq.size()) ? popq[i] : '1, e[i]);
        out_ready = 1'b0;
        step;
        check("t2_count_empty", 128'(count), 128'(0));

        // Streaming through a wrapping FIFO.
        reset_dut;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) e[i] = {8{16'h5A00 + 16'(i * 17)}};
        for (int i = 0; i < 10; i++) push(e[i]);
        wait_pops(10);
        for (int i = 0; i < 10; i++) begin
            check("t3_pop_order", (i < popq.size()) ? popq[i] : '1, e[i]);
            check("t3_write_addr", 128'((i < wq.size()) ? wq[i] : 16'hFFFF),
                  128'(BASE + 16'(16 * (i % 4))));
            check("t3_read_addr", 128'((i < rq.size()) ? rq[i] : 16'hFFFF),
                  128'(BASE + 16'(16 * (i % 4))));
        end
        out_ready = 1'b0;

        // Reset during READ_CAP with two entries stored.
        reset_dut;
        push({4{32'h1111_0000}});
        push({4{32'h1111_0001}});
        push({4{32'h1111_0002}});
        step;
        check("t4_count2", 128'(count), 128'(2));
        check("t4_out_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        step;                                   // pop, READ of entry 1
        out_ready = 1'b0;
        check("t4_read", 128'(sram_read), 128'(1));
        check("t4_read_addr", 128'(sram_addr), 128'(BASE + 16'd16));
        step;                                   // READ_CAP
        check("t4_cap_count", 128'(count), 128'(2));
        rst = 1'b1;
        #1;
        check("t4_rst_read", 128'(sram_read), 128'(0));
        check("t4_rst_addr", 128'(sram_addr), 128'(BASE));
        check("t4_rst_in_ready", 128'(in_ready), 128'(0));
        step;
        rst = 1'b0;
        #1;
        check("t4_after_out_valid", 128'(out_valid), 128'(0));
        check("t4_after_count", 128'(count), 128'(0));
        check("t4_after_read", 128'(sram_read), 128'(0));
        check("t4_after_in_ready", 128'(in_ready), 128'(0));
        step;
        wq.delete();
        push({4{32'hF00D_0000}});
        step;
        check("t4_new_write_count", 128'(wq.size()), 128'(1));
        check("t4_new_write_addr", 128'((wq.size() > 0) ? wq[0] : 16'hFFFF), 128'(BASE));
        step;
        step;
        step;
        check("t4_new_out_valid", 128'(out_valid), 128'(1));
        check("t4_new_out_data", out_data, {4{32'hF00D_0000}});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
        $fatal(1);
    end

endmodule
